// File: rtl/vend_dispenser_if.sv
// Request/status bundle between the vending FSM and the dispenser.
// The master side issues requests; the dispenser drives motor, coin and status lines.
interface vend_dispenser_if;
    logic       done;
    logic [1:0] product;
    logic [1:0] change;
    logic       motor_choc;
    logic       motor_drink;
    logic       coin_eject;
    logic       dispensed;
    logic       busy;
    logic       pend_full;
    logic       err;
    logic       overflow;

    modport master (
        output done, product, change,
        input  motor_choc, motor_drink, coin_eject, dispensed,
        input  busy, pend_full, err, overflow
    );

    modport slave (
        input  done, product, change,
        output motor_choc, motor_drink, coin_eject, dispensed,
        output busy, pend_full, err, overflow
    );
endinterface

// File: rtl/vend_dispenser.sv
// Product dispenser: runs a motor phase, ejects change coins with gaps between them,
// then pulses dispensed; one extra request can wait in a one-deep pending buffer.
module vend_dispenser #(
    parameter int MOTOR_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic            clk,
    input  logic            rst,
    vend_dispenser_if.slave bus
);

    typedef enum logic [2:0] {IDLE, MOTOR, COIN, GAP, FINISH} state_t;

    localparam logic [7:0] MOTOR_LOAD = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] coins, coins_nx;
    logic [1:0] prod, prod_nx;
    logic       pend_valid, pend_valid_nx;
    logic [1:0] pend_prod, pend_prod_nx;
    logic [1:0] pend_chg, pend_chg_nx;
    logic       err_q, err_nx;
    logic       ovf_q, ovf_nx;

    logic       req_valid;
    logic       launch;
    logic [1:0] launch_prod;
    logic [1:0] launch_chg;

    assign req_valid = bus.done && (bus.product != 2'd3) &&
                       !((bus.product == 2'd0) && (bus.change == 2'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            coins      <= 2'd0;
            prod       <= 2'd0;
            pend_valid <= 1'b0;
            pend_prod  <= 2'd0;
            pend_chg   <= 2'd0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            coins      <= coins_nx;
            prod       <= prod_nx;
            pend_valid <= pend_valid_nx;
            pend_prod  <= pend_prod_nx;
            pend_chg   <= pend_chg_nx;
            err_q      <= err_nx;
            ovf_q      <= ovf_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        coins_nx      = coins;
        prod_nx       = prod;
        pend_valid_nx = pend_valid;
        pend_prod_nx  = pend_prod;
        pend_chg_nx   = pend_chg;
        err_nx        = bus.done && (bus.product == 2'd3);
        ovf_nx        = 1'b0;
        launch        = 1'b0;
        launch_prod   = bus.product;
        launch_chg    = bus.change;

        case (state)
            IDLE: begin
                if (req_valid) launch = 1'b1;
            end
            MOTOR: begin
                if (cnt == 8'd0) state_nx = (coins != 2'd0) ? COIN : FINISH;
                else             cnt_nx   = cnt - 8'd1;
            end
            COIN: begin
                coins_nx = coins - 2'd1;
                if (coins == 2'd1) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt == 8'd0) state_nx = COIN;
                else             cnt_nx   = cnt - 8'd1;
            end
            FINISH: begin
                if (pend_valid) begin
                    launch        = 1'b1;
                    launch_prod   = pend_prod;
                    launch_chg    = pend_chg;
                    pend_valid_nx = 1'b0;
                end else if (req_valid) begin
                    launch = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // FINISH with an empty buffer launches the new request directly instead of storing it.
        if (req_valid && (state != IDLE) && !((state == FINISH) && !pend_valid)) begin
            if (!pend_valid || (state == FINISH)) begin
                pend_valid_nx = 1'b1;
                pend_prod_nx  = bus.product;
                pend_chg_nx   = bus.change;
            end else begin
                ovf_nx = 1'b1;
            end
        end

        if (launch) begin
            prod_nx  = launch_prod;
            coins_nx = launch_chg;
            if (launch_prod != 2'd0) begin
                state_nx = MOTOR;
                cnt_nx   = MOTOR_LOAD;
            end else begin
                state_nx = COIN;
            end
        end
    end

    always_comb begin
        bus.motor_choc  = (state == MOTOR) && (prod == 2'd1);
        bus.motor_drink = (state == MOTOR) && (prod == 2'd2);
        bus.coin_eject  = (state == COIN);
        bus.dispensed   = (state == FINISH);
        bus.busy        = (state != IDLE);
        bus.pend_full   = pend_valid;
        bus.err         = err_q;
        bus.overflow    = ovf_q;
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser: directed timing checks plus random traffic
// compared every cycle against a job-timeline model built from offsets within each request.
module tb_vend_dispenser;

    localparam int M = 4;
    localparam int G = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    vend_dispenser_if vif ();

    vend_dispenser #(.MOTOR_CYCLES(M), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the active job is described only by its product, change and cycle offset.
    bit         m_active = 1'b0;
    logic [1:0] m_prod   = 2'd0;
    logic [1:0] m_chg    = 2'd0;
    int         m_off    = 0;
    int         m_len    = 0;
    bit         m_pv     = 1'b0;
    logic [1:0] m_pp     = 2'd0;
    logic [1:0] m_pc     = 2'd0;
    bit         m_err    = 1'b0;
    bit         m_ovf    = 1'b0;

    function automatic int jobLen(input logic [1:0] p, input logic [1:0] c);
        int base;
        base = (p != 2'd0) ? M : 0;
        if (c == 2'd0) return base + 1;
        return base + int'(c) + (int'(c) - 1) * G + 1;
    endfunction

    task automatic modelStart(input logic [1:0] p, input logic [1:0] c);
        m_active = 1'b1;
        m_prod   = p;
        m_chg    = c;
        m_off    = 0;
        m_len    = jobLen(p, c);
    endtask

    initial forever begin
        bit valid;
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_active = 1'b0;
            m_pv     = 1'b0;
            m_err    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            valid = vif.done && (vif.product != 2'd3) &&
                    !((vif.product == 2'd0) && (vif.change == 2'd0));
            m_err = vif.done && (vif.product == 2'd3);
            m_ovf = 1'b0;
            if (!m_active) begin
                if (valid) modelStart(vif.product, vif.change);
            end else if (m_off == m_len - 1) begin
                if (m_pv) begin
                    modelStart(m_pp, m_pc);
                    m_pv = valid;
                    m_pp = vif.product;
                    m_pc = vif.change;
                end else if (valid) begin
                    modelStart(vif.product, vif.change);
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_off++;
                if (valid) begin
                    if (m_pv) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_pv = 1'b1;
                        m_pp = vif.product;
                        m_pc = vif.change;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic d, input logic [1:0] p, input logic [1:0] c);
        vif.done    = d;
        vif.product = p;
        vif.change  = c;
    endtask

    task automatic expectAll(input string tag, input logic mc, input logic md, input logic ce,
                             input logic ds, input logic bz, input logic pf, input logic er,
                             input logic ov);
        checkOutput({tag, " motor_choc"},  vif.motor_choc,  mc);
        checkOutput({tag, " motor_drink"}, vif.motor_drink, md);
        checkOutput({tag, " coin_eject"},  vif.coin_eject,  ce);
        checkOutput({tag, " dispensed"},   vif.dispensed,   ds);
        checkOutput({tag, " busy"},        vif.busy,        bz);
        checkOutput({tag, " pend_full"},   vif.pend_full,   pf);
        checkOutput({tag, " err"},         vif.err,         er);
        checkOutput({tag, " overflow"},    vif.overflow,    ov);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((vif.busy || vif.pend_full) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " reaches idle"}, vif.busy | vif.pend_full, 1'b0);
        @(negedge clk);
    endtask

    initial forever begin
        int  base;
        logic exp_coin;
        @(negedge clk);
        if (cmp_en) begin
            base     = (m_prod != 2'd0) ? M : 0;
            exp_coin = m_active && (m_chg != 2'd0) && (m_off >= base) &&
                       (m_off < m_len - 1) && (((m_off - base) % (G + 1)) == 0);
            checkOutput("model motor_choc",  vif.motor_choc,  m_active && m_prod == 2'd1 && m_off < M);
            checkOutput("model motor_drink", vif.motor_drink, m_active && m_prod == 2'd2 && m_off < M);
            checkOutput("model coin_eject",  vif.coin_eject,  exp_coin);
            checkOutput("model dispensed",   vif.dispensed,   m_active && m_off == m_len - 1);
            checkOutput("model busy",        vif.busy,        m_active);
            checkOutput("model pend_full",   vif.pend_full,   m_pv);
            checkOutput("model err",         vif.err,         m_err);
            checkOutput("model overflow",    vif.overflow,    m_ovf);
        end
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0);
        #1;
        expectAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 2'd1, 2'd0);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            applyStimulus(1'b0, 2'd0, 2'd0);
            expectAll($sformatf("choc c%0d", n), n <= 4, 0, 0, n == 5, n <= 5, 0, 0, 0);
        end
        waitIdle("choc");

        applyStimulus(1'b1, 2'd2, 2'd2);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            applyStimulus(1'b0, 2'd0, 2'd0);
            expectAll($sformatf("drink c%0d", n), 0, n <= 4, n == 5 || n == 8, n == 9, n <= 9, 0, 0, 0);
        end
        waitIdle("drink");

        applyStimulus(1'b1, 2'd0, 2'd3);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            applyStimulus(1'b0, 2'd0, 2'd0);
            expectAll($sformatf("refund c%0d", n), 0, 0, n == 1 || n == 4 || n == 7, n == 8, n <= 8, 0, 0, 0);
        end
        waitIdle("refund");

        applyStimulus(1'b1, 2'd1, 2'd0);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 2)      applyStimulus(1'b1, 2'd2, 2'd1);
            else if (n == 3) applyStimulus(1'b1, 2'd1, 2'd0);
            else             applyStimulus(1'b0, 2'd0, 2'd0);
            expectAll($sformatf("pend c%0d", n), n <= 4, n >= 6, 0, n == 5, 1,
                      n >= 3 && n <= 5, 0, n == 4);
        end
        waitIdle("pend");

        applyStimulus(1'b1, 2'd3, 2'd1);
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            applyStimulus(1'b0, 2'd0, 2'd0);
            expectAll($sformatf("invalid c%0d", n), 0, 0, 0, 0, 0, 0, n == 1, 0);
        end
        applyStimulus(1'b1, 2'd0, 2'd0);
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            applyStimulus(1'b0, 2'd0, 2'd0);
            expectAll($sformatf("empty c%0d", n), 0, 0, 0, 0, 0, 0, 0, 0);
        end

        applyStimulus(1'b1, 2'd1, 2'd2);
        @(negedge clk);
        applyStimulus(1'b0, 2'd0, 2'd0);
        @(negedge clk);
        checkOutput("abort motor before reset", vif.motor_choc, 1'b1);
        #2 rst = 1'b0;
        #1;
        expectAll("abort during reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        applyStimulus(1'b1, 2'd2, 2'd0);
        @(negedge clk);
        applyStimulus(1'b0, 2'd0, 2'd0);
        expectAll("first edge after reset", 0, 1, 0, 0, 1, 0, 0, 0);
        waitIdle("after reset");

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                applyStimulus(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            else
                applyStimulus(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        applyStimulus(1'b0, 2'd0, 2'd0);
        waitIdle("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
